// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment display paths.
//   SEG7_TABLE     hex nibble -> segment code, bit order {a,b,c,d,e,f,g}
//   SEG_W / NIB_W  segment bus width (incl. dp) and nibble width
//   frame_state_e  frame assembly FSM states of the scan decoder
package seg7_pkg;

    localparam int SEG_W = 8;
    localparam int NIB_W = 4;

    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef enum logic {
        COLLECT  = 1'b0,
        COMPLETE = 1'b1
    } frame_state_e;

endpackage

// File: rtl/seg7_pattern_dec.sv
// seg7_pattern_dec: combinational inverse of the hex->segment table.
//   pat_i  in   7  segment pattern {a..g}, dp excluded
//   hit_o  out  1  pattern matched one of the 16 hex codes
//   nib_o  out  4  decoded nibble, 0 when no match
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [6:0]       pat_i,
    output logic             hit_o,
    output logic [NIB_W-1:0] nib_o
);

    // Table entries are unique, so at most one index can match.
    always_comb begin
        hit_o = 1'b0;
        nib_o = '0;
        for (int i = 0; i < 16; i++) begin
            if (pat_i == SEG7_TABLE[i]) begin
                hit_o = 1'b1;
                nib_o = NIB_W'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: monitors a scanned 7-segment bus, decodes each stable
// digit back to its hex nibble and hands out complete NDIG-digit frames over
// a valid/ready handshake.
//   clk, rst_n   clock (rising edge) and async active-low reset
//   seg_i        segment bus, [7]=a .. [1]=g, [0]=dp, active-high
//   dig_sel_i    one-hot digit select; zero or multi-hot samples are ignored
//   val_o        decoded frame, digit k at [4k+3:4k]
//   err_o        per-digit "pattern matched no hex code"
//   valid_o      frame available, ready_i accepts it
//   overrun_o    sticky: a completed frame was dropped
//   dp_o         per-digit dp bit (only with SEG7DEC_DP_EN)
// Build option SEG7DEC_DP_EN: adds dp_o, captures dp and includes it in the
// stability compare. Without it seg_i[0] is ignored entirely.
//
// state    | meaning
// COLLECT  | gathering digits, captured mask not yet all-ones
// COMPLETE | one cycle: mask full, publish frame or flag overrun
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEG_W-1:0]      seg_i,
    input  logic [NDIG-1:0]       dig_sel_i,
    output logic [NIB_W*NDIG-1:0] val_o,
    output logic [NDIG-1:0]       err_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o
`ifdef SEG7DEC_DP_EN
    ,
    output logic [NDIG-1:0]       dp_o
`endif
);

`ifdef SEG7DEC_DP_EN
    localparam int CMP_W = SEG_W;
`else
    localparam int CMP_W = SEG_W - 1;
`endif
    // Accept fires on the sample that brings the run to STABLE_CYC identical
    // samples; the counter then parks at CNT_MAX so it cannot re-fire.
    localparam logic [7:0] CNT_ACC = 8'(STABLE_CYC - 2);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

    logic [CMP_W-1:0] seg_cmp;
`ifdef SEG7DEC_DP_EN
    assign seg_cmp = seg_i;
`else
    logic seg_dp_unused;
    assign seg_cmp       = seg_i[SEG_W-1:1];
    assign seg_dp_unused = seg_i[0];
`endif

    logic [NDIG-1:0]        prev_sel_q;
    logic [CMP_W-1:0]       prev_seg_q;
    logic [7:0]             cnt_q, cnt_d;
    logic                   sel_onehot, same, accept;
    logic [NDIG-1:0]        acc_bits, mask_q, mask_acc;
    logic                   hit;
    logic [NIB_W-1:0]       nib;
    logic [NIB_W*NDIG-1:0]  stg_val_q, val_q;
    logic [NDIG-1:0]        stg_err_q, err_q;
    logic                   valid_q, overrun_q;
    frame_state_e           state_q;

    seg7_pattern_dec u_dec (
        .pat_i (seg_i[SEG_W-1:1]),
        .hit_o (hit),
        .nib_o (nib)
    );

    assign sel_onehot = (dig_sel_i != '0) && ((dig_sel_i & (dig_sel_i - NDIG'(1))) == '0);
    assign same       = sel_onehot && (dig_sel_i == prev_sel_q) && (seg_cmp == prev_seg_q);
    assign accept     = same && (cnt_q == CNT_ACC);
    assign acc_bits   = accept ? dig_sel_i : '0;
    assign mask_acc   = mask_q | acc_bits;

    always_comb begin
        cnt_d = '0;
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
        end
    end

`ifdef SEG7DEC_DP_EN
    logic [NDIG-1:0] stg_dp_q, dp_q;
`endif

    // Sampling and per-digit staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sel_q <= '0;
            prev_seg_q <= '0;
            cnt_q      <= '0;
            stg_val_q  <= '0;
            stg_err_q  <= '0;
`ifdef SEG7DEC_DP_EN
            stg_dp_q   <= '0;
`endif
        end else begin
            prev_sel_q <= dig_sel_i;
            prev_seg_q <= seg_cmp;
            cnt_q      <= cnt_d;
            for (int k = 0; k < NDIG; k++) begin
                if (acc_bits[k]) begin
                    stg_val_q[NIB_W*k +: NIB_W] <= nib;
                    stg_err_q[k]                <= ~hit;
`ifdef SEG7DEC_DP_EN
                    stg_dp_q[k]                 <= seg_i[0];
`endif
                end
            end
        end
    end

    // Frame FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            mask_q    <= '0;
            val_q     <= '0;
            err_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SEG7DEC_DP_EN
            dp_q      <= '0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    mask_q <= mask_acc;
                    if (mask_acc == '1) begin
                        state_q <= COMPLETE;
                    end
                    if (valid_q && ready_i) begin
                        valid_q <= 1'b0;
                    end
                end
                COMPLETE: begin
                    mask_q  <= acc_bits;
                    state_q <= COLLECT;
                    // Load when the output slot is free or being drained now.
                    if (!valid_q || ready_i) begin
                        val_q   <= stg_val_q;
                        err_q   <= stg_err_q;
`ifdef SEG7DEC_DP_EN
                        dp_q    <= stg_dp_q;
`endif
                        valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign val_o     = val_q;
    assign err_o     = err_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
`ifdef SEG7DEC_DP_EN
    assign dp_o      = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder (NDIG=4, STABLE_CYC=4). Directed scenarios
// compare against fixed expected frames; a cycle-level reference model built
// from run-length-of-identical-samples rules checks every output each cycle,
// including under randomized scan traffic and random ready.
module tb_seg7_scan_decoder;

    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 4;

    localparam logic [7:0] P_F   = 8'b10001110;
    localparam logic [7:0] P_7   = 8'b11100000;
    localparam logic [7:0] P_A   = 8'b11101110;
    localparam logic [7:0] P_3   = 8'b11110010;
    localparam logic [7:0] P_BAD = 8'b00000010;
    localparam logic [7:0] P_1   = 8'b01100000;
    localparam logic [7:0] P_2   = 8'b11011010;
    localparam logic [7:0] P_4   = 8'b01100110;
    localparam logic [7:0] P_5   = 8'b10110110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg_i = '0;
    logic [3:0]  dig_sel_i = '0;
    logic        ready_i = 1'b0;
    logic [15:0] val_o;
    logic [3:0]  err_o;
    logic        valid_o;
    logic        overrun_o;
`ifdef SEG7DEC_DP_EN
    logic [3:0]  dp_o;
`endif

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_i     (seg_i),
        .dig_sel_i (dig_sel_i),
        .val_o     (val_o),
        .err_o     (err_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .overrun_o (overrun_o)
`ifdef SEG7DEC_DP_EN
        ,
        .dp_o      (dp_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference segment codes for hex 0..F, {a..g}.
    logic [6:0] seg_code [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Returns {err, nibble}.
    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (seg_code[i] == p) return {1'b0, 4'(i)};
        end
        return 5'b10000;
    endfunction

    // ---------------- reference model ----------------
    int          m_run = 0;
    logic [3:0]  m_last_sel = '0;
    logic [7:0]  m_last_key = '0;
    logic [3:0]  m_capt = '0;
    logic [15:0] m_stg_val = '0;
    logic [3:0]  m_stg_err = '0;
    bit          m_done = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_ovr = 1'b0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_err = '0;
`ifdef SEG7DEC_DP_EN
    logic [3:0]  m_stg_dp = '0;
    logic [3:0]  m_dp = '0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_last_sel = '0; m_last_key = '0; m_capt = '0;
            m_stg_val = '0; m_stg_err = '0; m_done = 1'b0;
            m_valid = 1'b0; m_ovr = 1'b0; m_val = '0; m_err = '0;
`ifdef SEG7DEC_DP_EN
            m_stg_dp = '0; m_dp = '0;
`endif
        end else begin : step
            logic [7:0] key;
            logic [4:0] dec;
            int         d;
            bit         hs;
            hs = m_valid && ready_i;
            if (m_done) begin
                if (!m_valid || hs) begin
                    m_val = m_stg_val;
                    m_err = m_stg_err;
`ifdef SEG7DEC_DP_EN
                    m_dp  = m_stg_dp;
`endif
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (hs) begin
                m_valid = 1'b0;
            end
            m_done = 1'b0;
`ifdef SEG7DEC_DP_EN
            key = seg_i;
`else
            key = {seg_i[7:1], 1'b0};
`endif
            if ($countones(dig_sel_i) == 1) begin
                if (dig_sel_i == m_last_sel && key == m_last_key) m_run++;
                else m_run = 1;
                if (m_run == STABLE_CYC) begin
                    d = 0;
                    for (int i = 0; i < 4; i++) if (dig_sel_i[i]) d = i;
                    dec = ref_decode(seg_i[7:1]);
                    m_stg_val[4*d +: 4] = dec[3:0];
                    m_stg_err[d] = dec[4];
`ifdef SEG7DEC_DP_EN
                    m_stg_dp[d] = seg_i[0];
`endif
                    m_capt[d] = 1'b1;
                    if (m_capt == 4'hF) begin
                        m_done = 1'b1;
                        m_capt = '0;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_last_sel = dig_sel_i;
            m_last_key = key;
        end
    end

    // Every cycle: outputs against the model.
    always begin
        @(posedge clk);
        #2;
        chk("valid", 32'(valid_o), 32'(m_valid));
        chk("val", 32'(val_o), 32'(m_val));
        chk("err", 32'(err_o), 32'(m_err));
        chk("overrun", 32'(overrun_o), 32'(m_ovr));
`ifdef SEG7DEC_DP_EN
        chk("dp", 32'(dp_o), 32'(m_dp));
`endif
    end

    // Frame consumption log for directed scenarios.
    int          frames = 0;
    logic [15:0] last_val = '0;
    logic [3:0]  last_err = '0;
    always begin
        @(negedge clk);
        #3;
        if (rst_n && valid_o && ready_i) begin
            frames++;
            last_val = val_o;
            last_err = err_o;
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_rdy = 1'b0;

    task automatic drive(input logic [3:0] sel, input logic [7:0] seg, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dig_sel_i = sel;
            seg_i     = seg;
            if (rnd_rdy) ready_i = 1'($urandom);
        end
    endtask

    task automatic sweep(input logic [7:0] p0, input logic [7:0] p1,
                         input logic [7:0] p2, input logic [7:0] p3, input int hold);
        drive(4'b0001, p0, hold);
        drive(4'b0010, p1, hold);
        drive(4'b0100, p2, hold);
        drive(4'b1000, p3, hold);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        dig_sel_i = '0;
        seg_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int f0;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_val", 32'(val_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_overrun", 32'(overrun_o), 32'h0);
        rst_n = 1'b1;

        // Basic frame F,7,A,3.
        ready_i = 1'b1;
        f0 = frames;
        sweep(P_F, P_7, P_A, P_3, 6);
        drive(4'b0000, 8'h00, 4);
        chk("basic_frames", 32'(frames - f0), 32'd1);
        chk("basic_val", 32'(last_val), 32'h3A7F);
        chk("basic_err", 32'(last_err), 32'h0);

        // Unknown pattern on digit 2.
        f0 = frames;
        sweep(P_F, P_7, P_BAD, P_3, 6);
        drive(4'b0000, 8'h00, 4);
        chk("bad_frames", 32'(frames - f0), 32'd1);
        chk("bad_val", 32'(last_val), 32'h307F);
        chk("bad_err", 32'(last_err), 32'h4);

        // Digit 1 too short: no frame, then a full sweep gives one.
        do_reset();
        f0 = frames;
        drive(4'b0001, P_F, 6);
        drive(4'b0010, P_7, 3);
        drive(4'b0100, P_A, 6);
        drive(4'b1000, P_3, 6);
        drive(4'b0000, 8'h00, 4);
        chk("short_noframe", 32'(frames - f0), 32'd0);
        sweep(P_F, P_7, P_A, P_3, 6);
        drive(4'b0000, 8'h00, 4);
        chk("short_next_frames", 32'(frames - f0), 32'd1);
        chk("short_next_val", 32'(last_val), 32'h3A7F);

        // Back-pressure across two sweeps.
        do_reset();
        ready_i = 1'b0;
        f0 = frames;
        sweep(P_F, P_7, P_A, P_3, 6);
        drive(4'b0000, 8'h00, 3);
        chk("bp_valid1", 32'(valid_o), 32'd1);
        chk("bp_val1", 32'(val_o), 32'h3A7F);
        chk("bp_ovr1", 32'(overrun_o), 32'd0);
        sweep(P_1, P_2, P_4, P_5, 6);
        drive(4'b0000, 8'h00, 3);
        chk("bp_valid2", 32'(valid_o), 32'd1);
        chk("bp_val_held", 32'(val_o), 32'h3A7F);
        chk("bp_ovr2", 32'(overrun_o), 32'd1);
        @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_drain_valid", 32'(valid_o), 32'd0);
        chk("bp_drain_frames", 32'(frames - f0), 32'd1);
        chk("bp_drain_val", 32'(last_val), 32'h3A7F);
        chk("bp_ovr_sticky", 32'(overrun_o), 32'd1);

        // Reset after two digits captured.
        ready_i = 1'b1;
        drive(4'b0001, P_F, 6);
        drive(4'b0010, P_7, 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_val", 32'(val_o), 32'h0);
        chk("mid_rst_err", 32'(err_o), 32'h0);
        chk("mid_rst_valid", 32'(valid_o), 32'h0);
        chk("mid_rst_overrun", 32'(overrun_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        f0 = frames;
        drive(4'b0100, P_A, 6);
        drive(4'b1000, P_3, 6);
        drive(4'b0000, 8'h00, 4);
        chk("mid_rst_partial", 32'(frames - f0), 32'd0);
        sweep(P_F, P_7, P_A, P_3, 6);
        drive(4'b0000, 8'h00, 6);
        chk("mid_rst_frames", 32'(frames - f0), 32'd1);
        chk("mid_rst_frame_val", 32'(last_val), 32'h3A7F);

        // Blanking and multi-hot selects inserted mid-sweep.
        do_reset();
        f0 = frames;
        drive(4'b0001, P_F, 6);
        drive(4'b0000, 8'h00, 2);
        drive(4'b0010, P_7, 3);
        drive(4'b0110, P_7, 2);
        drive(4'b0010, P_7, 6);
        drive(4'b0110, P_A, 2);
        drive(4'b0100, P_A, 6);
        drive(4'b1000, P_3, 6);
        drive(4'b0000, 8'h00, 4);
        chk("blank_frames", 32'(frames - f0), 32'd1);
        chk("blank_val", 32'(last_val), 32'h3A7F);

`ifdef SEG7DEC_DP_EN
        sweep(P_F, P_7, P_A | 8'h01, P_3, 6);
        drive(4'b0000, 8'h00, 4);
        chk("dp_frame", 32'(dp_o), 32'h4);
`endif

        // Randomized structured sweeps with random ready.
        do_reset();
        rnd_rdy = 1'b1;
        for (int s = 0; s < 25; s++) begin
            logic [7:0] p [4];
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 7) == 0) p[k] = 8'($urandom);
                else p[k] = {seg_code[4'($urandom_range(0, 15))], 1'($urandom)};
            end
            sweep(p[0], p[1], p[2], p[3], int'($urandom_range(3, 7)));
        end

        // Fully random scan traffic.
        for (int s = 0; s < 150; s++) begin
            logic [3:0] sel;
            logic [7:0] seg;
            int         r;
            r = int'($urandom_range(0, 9));
            if (r < 8)       sel = 4'(1 << $urandom_range(0, 3));
            else if (r == 8) sel = 4'b0000;
            else             sel = 4'(4'b0011 << $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) seg = 8'($urandom);
            else seg = {seg_code[4'($urandom_range(0, 15))], 1'($urandom)};
            drive(sel, seg, int'($urandom_range(1, 8)));
        end
        rnd_rdy = 1'b0;
        ready_i = 1'b1;
        drive(4'b0000, 8'h00, 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
